rev_chunk_deser: RTL and testbench

Chunked deserializer that receives a bit-reversed vector as a stream of CHUNK-bit slices and reassembles the original, un-reversed WIDTH-bit word. It is the receiving end of the vector-reversal path: the producer emits reversed vectors sliced LSB-chunk-first, and this block restores bit order and presents whole words to the consumer. Both sides use valid/ready handshakes.

---
 rtl/rev_chunk_deser_pkg.sv | 21 ++
 rtl/rev_chunk_deser_par_chk.sv | 22 ++
 rtl/rev_chunk_deser.sv | 125 ++++++++++++
 tb/tb_rev_chunk_deser.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rev_chunk_deser_pkg.sv
// rev_chunk_deser_pkg
//   Shared types and constants for the chunked bit-reversal deserializer.
//   - state_t : FILL (collecting slices) / HOLD (presenting a word)
//   - cnt_w() : width of the slice counter for N slices per word
//   - DEF_WIDTH / DEF_CHUNK : default word and slice widths
package rev_chunk_deser_pkg;

  localparam int DEF_WIDTH = 100;
  localparam int DEF_CHUNK = 10;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // A single-slice word still needs a one-bit counter.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rev_chunk_deser_par_chk.sv
// rev_chunk_par_chk
//   Even-parity check of one input slice; only present when
//   REV_CHUNK_DESER_PARITY_EN is defined.
//   Ports:
//     data  in  CHUNK  slice payload
//     par   in  1      even parity bit sent with the slice
//     bad   out 1      1 when data and par together have odd parity
`ifdef REV_CHUNK_DESER_PARITY_EN
module rev_chunk_par_chk
  import rev_chunk_deser_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] data,
  input  logic             par,
  output logic             bad
);

  assign bad = (^data) ^ par;

endmodule
`endif

// File: rtl/rev_chunk_deser.sv
// rev_chunk_deser
//   Receives a bit-reversed WIDTH-bit vector as WIDTH/CHUNK slices
//   (LSB slice first) and presents the restored, un-reversed word.
//   Optional feature macro: REV_CHUNK_DESER_PARITY_EN (slice parity check).
//   Ports:
//     clk, resetn           clock, synchronous active-low reset
//     in_valid/in_ready     slice handshake, in_data = one CHUNK slice
//     out_valid/out_ready   word handshake, out_data = restored word
//     in_par                (parity build) even parity of in_data
//     out_err               (parity build) word contained a bad slice
//     err_sticky            (parity build) any bad slice since reset
module rev_chunk_deser
  import rev_chunk_deser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CHUNK-1:0] in_data,
`ifdef REV_CHUNK_DESER_PARITY_EN
  input  logic             in_par,
  output logic             out_err,
  output logic             err_sticky,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = cnt_w(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] k_q;
  logic [WIDTH-1:0] word_p0;
  logic [CHUNK-1:0] slice_rev;
  logic             in_hs;

  // Handshake outputs are decoded from state alone.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && (k_q == LAST)) state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  assign in_hs = in_valid & in_ready;

  // in_data[j] lands at word bit WIDTH-1-k*CHUNK-j, i.e. the slice is
  // bit-reversed and stored in slot N-1-k.
  always_comb begin
    slice_rev = '0;
    for (int j = 0; j < CHUNK; j++) slice_rev[j] = in_data[CHUNK-1-j];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= FILL;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      if (in_hs) k_q <= (k_q == LAST) ? '0 : k_q + CNT_W'(1);
    end
  end

  // Stage p0: reassembly buffer. Slots are only rewritten by their own
  // slice, so no clearing between words.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      word_p0 <= '0;
    end else if (in_hs) begin
      for (int s = 0; s < N; s++)
        if (k_q == CNT_W'(s)) word_p0[(N-1-s)*CHUNK +: CHUNK] <= slice_rev;
    end
  end

  assign out_data = word_p0;

`ifdef REV_CHUNK_DESER_PARITY_EN
  logic slice_bad;
  logic err_q;
  logic sticky_q;

  rev_chunk_par_chk #(
    .CHUNK(CHUNK)
  ) u_par_chk (
    .data(in_data),
    .par (in_par),
    .bad (slice_bad)
  );

  // The first slice of a word restarts the per-word flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      if (in_hs) begin
        err_q <= (k_q == '0) ? slice_bad : (err_q | slice_bad);
        if (slice_bad) sticky_q <= 1'b1;
      end else if (out_valid && out_ready) begin
        err_q <= 1'b0;
      end
    end
  end

  assign out_err    = err_q;
  assign err_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_rev_chunk_deser.sv
// tb_rev_chunk_deser
//   Directed and randomized bench for rev_chunk_deser. Words are chosen
//   as the expected output, reversed by the bench, and streamed as slices.
module tb_rev_chunk_deser;

  localparam int W = 100;
  localparam int C = 10;
  localparam int N = W / C;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [C-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
`ifdef REV_CHUNK_DESER_PARITY_EN
  logic         in_par = 1'b0;
  logic         out_err;
  logic         err_sticky;
  int           bad_k = -1;
  logic         sticky_exp = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  rev_chunk_deser #(
    .WIDTH(W),
    .CHUNK(C)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef REV_CHUNK_DESER_PARITY_EN
    .in_par    (in_par),
    .out_err   (out_err),
    .err_sticky(err_sticky),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (resetn && in_valid && in_ready) hs_cnt <= hs_cnt + 1;

  function automatic logic [W-1:0] revw(input logic [W-1:0] w);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = w[W-1-i];
    return r;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push_slice(input logic [C-1:0] d, input bit bub, input int k);
    int guard;
    if (bub)
      while ($urandom_range(1, 0) == 1) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    in_valid = 1'b1;
    in_data  = d;
`ifdef REV_CHUNK_DESER_PARITY_EN
    in_par = (^d) ^ (k == bad_k);
    if (k == bad_k) sticky_exp = 1'b1;
`else
    if (k < 0) in_data = ~d;
`endif
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    chk1("slice_rdy", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic rand_word(output logic [W-1:0] w);
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    w = t[W-1:0];
  endtask

  // Streams reversed w, optionally stalls the consumer for hold cycles
  // with in_valid asserted, then completes the word handshake.
  task automatic send_word(input logic [W-1:0] w, input int hold, input bit bub, input string tag);
    logic [W-1:0] r;
    logic [W-1:0] junk;
    int hs0;
    r   = revw(w);
    hs0 = hs_cnt;
    out_ready = (hold == 0);
    for (int k = 0; k < N; k++) push_slice(r[k*C +: C], bub, k);
    @(negedge clk);
    chk1({tag, "_vld"}, out_valid, 1'b1);
    chkw({tag, "_data"}, out_data, w);
    chk1({tag, "_rdy"}, in_ready, 1'b0);
    chki({tag, "_hs"}, hs_cnt - hs0, N);
`ifdef REV_CHUNK_DESER_PARITY_EN
    chk1({tag, "_err"}, out_err, bad_k >= 0);
    chk1({tag, "_sticky"}, err_sticky, sticky_exp);
`endif
    for (int i = 0; i < hold; i++) begin
      rand_word(junk);
      in_valid = 1'b1;
      in_data  = junk[C-1:0];
      @(negedge clk);
      chk1({tag, "_hold_vld"}, out_valid, 1'b1);
      chkw({tag, "_hold_data"}, out_data, w);
      chk1({tag, "_hold_rdy"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk1({tag, "_vld_drop"}, out_valid, 1'b0);
    chk1({tag, "_rdy_back"}, in_ready, 1'b1);
    chki({tag, "_hs_total"}, hs_cnt - hs0, N);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [W-1:0] w;
    logic [W-1:0] ones;

    // Reset state
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk1("rst_vld", out_valid, 1'b0);
    chk1("rst_rdy", in_ready, 1'b1);
    chkw("rst_data", out_data, '0);
`ifdef REV_CHUNK_DESER_PARITY_EN
    chk1("rst_err", out_err, 1'b0);
    chk1("rst_sticky", err_sticky, 1'b0);
`endif
    @(posedge clk); #1;

    // Single set bit at either end of the word
    w = '0; w[W-1] = 1'b1;
    send_word(w, 0, 1'b0, "msb");
    w = '0; w[0] = 1'b1;
    send_word(w, 0, 1'b0, "lsb");

    // One all-ones slice at a time
    ones = '0;
    ones[C-1:0] = '1;
    for (int k = 0; k < N; k += 3)
      send_word(ones << (W - C - k*C), 0, 1'b0, "slice_ones");

    // Consumer stall with producer pushing, then a fresh word
    rand_word(w);
    send_word(w, 5, 1'b0, "stall");
    rand_word(w);
    send_word(w, 0, 1'b0, "after_stall");

    // Random words with random bubbles
    for (int n = 0; n < 20; n++) begin
      rand_word(w);
      send_word(w, n % 3, 1'b1, "rand");
    end

    // Reset in the middle of a word
    rand_word(w);
    for (int k = 0; k < 4; k++) push_slice(w[k*C +: C], 1'b0, k);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk1("midrst_vld", out_valid, 1'b0);
    chk1("midrst_rdy", in_ready, 1'b1);
    chkw("midrst_data", out_data, '0);
    @(posedge clk); #1;
    rand_word(w);
    send_word(w, 0, 1'b0, "post_rst");

`ifdef REV_CHUNK_DESER_PARITY_EN
    bad_k = 3;
    rand_word(w);
    send_word(w, 0, 1'b0, "par_bad");
    bad_k = -1;
    rand_word(w);
    send_word(w, 0, 1'b0, "par_clean");
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    sticky_exp = 1'b0;
    @(negedge clk);
    chk1("par_sticky_clr", err_sticky, 1'b0);
    @(posedge clk); #1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound on simulated time.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
